// File: rtl/mips_pkg.sv
// Shared MIPS core types: register tags, opcodes, data width and the hazard-tracking stage record.
package mips_pkg;

  localparam int unsigned DATA_32_W = 32;

  typedef logic [4:0] t_instr_register;
  localparam t_instr_register ZERO = 5'd0;

  typedef enum logic [3:0] {
    NEM_NOP = 4'd0,
    NEM_ADD = 4'd1,
    NEM_SUB = 4'd2,
    NEM_LW  = 4'd3,
    NEM_SW  = 4'd4
  } t_instr_pnmen;

  typedef struct packed {
    logic            v;
    t_instr_register rsd;
    t_instr_pnmen    opcode;
    logic            reg_write;
  } t_hzd_stage;

  localparam t_hzd_stage HZD_BUBBLE = '{v: 1'b0, rsd: ZERO, opcode: NEM_NOP, reg_write: 1'b0};

  // A stage may forward only if it really writes a non-zero register.
  function automatic logic hzd_free(input t_hzd_stage s);
    return s.v & s.reg_write & (s.rsd != ZERO);
  endfunction

endpackage

// File: rtl/mips_sat_counter.sv
// Saturating event counter; holds at all-ones until reset.
module mips_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en && inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mips_hzd_pipe.sv
// Tracks destination tags and write qualifiers from E down to W+1 for the forwarding unit,
// with decode stall, execute flush, memory-wait freeze and a load-to-use event counter.
module mips_hzd_pipe
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_wait,
  input  logic                 stall_d,
  input  logic                 flush_e,
  input  logic                 valid_d,
  input  t_instr_register      rs1_d,
  input  t_instr_register      rs2_d,
  input  t_instr_register      rsd_d,
  input  t_instr_pnmen         intr_opcode_d,
  input  logic                 reg_write_d,
  input  logic [DATA_32_W-1:0] reg_file_rd_data_1_d,
  input  logic [DATA_32_W-1:0] reg_file_rd_data_2_d,
  input  logic [DATA_32_W-1:0] data_mem_bus_rd_data_m,
  output t_instr_register      rs1_e,
  output t_instr_register      rs2_e,
  output t_instr_register      rsd_e,
  output t_instr_pnmen         intr_opcode_e,
  output logic                 reg_write_e,
  output logic [DATA_32_W-1:0] reg_file_rd_data_1_e,
  output logic [DATA_32_W-1:0] reg_file_rd_data_2_e,
  output t_instr_register      rsd_m,
  output t_instr_register      rsd_w,
  output t_instr_register      rsd_w_plus1,
  output t_instr_pnmen         intr_opcode_m,
  output t_instr_pnmen         intr_opcode_w,
  output t_instr_pnmen         intr_opcode_w_plus1,
  output logic                 reg_write_m,
  output logic                 reg_write_w,
  output logic                 reg_write_hzd_free_m,
  output logic                 reg_write_hzd_free_w,
  output logic                 reg_write_hzd_free_w_plus1,
  output logic [DATA_32_W-1:0] data_mem_bus_rd_data_w,
  output logic [DATA_32_W-1:0] data_mem_bus_rd_data_w_plus1,
  output logic [CNT_W-1:0]     load2use_cnt
);

  t_hzd_stage stage_e_d, stage_e_q, stage_m_q, stage_w_q, stage_wp1_q;
  t_instr_register rs1_e_d, rs2_e_d, rs1_e_q, rs2_e_q;
  logic [DATA_32_W-1:0] rd1_e_d, rd2_e_d, rd1_e_q, rd2_e_q;
  logic [DATA_32_W-1:0] ld_w_q, ld_wp1_q;
  logic free_m_q, free_w_q, free_wp1_q;
  logic e_bubble, load2use;

  always_comb begin
    e_bubble  = flush_e | stall_d | ~valid_d;
    stage_e_d = HZD_BUBBLE;
    rs1_e_d   = ZERO;
    rs2_e_d   = ZERO;
    rd1_e_d   = '0;
    rd2_e_d   = '0;
    if (!e_bubble) begin
      stage_e_d = '{v: 1'b1, rsd: rsd_d, opcode: intr_opcode_d, reg_write: reg_write_d};
      rs1_e_d   = rs1_d;
      rs2_e_d   = rs2_d;
      rd1_e_d   = reg_file_rd_data_1_d;
      rd2_e_d   = reg_file_rd_data_2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_e_q   <= HZD_BUBBLE;
      stage_m_q   <= HZD_BUBBLE;
      stage_w_q   <= HZD_BUBBLE;
      stage_wp1_q <= HZD_BUBBLE;
      rs1_e_q     <= ZERO;
      rs2_e_q     <= ZERO;
      rd1_e_q     <= '0;
      rd2_e_q     <= '0;
      ld_w_q      <= '0;
      ld_wp1_q    <= '0;
      free_m_q    <= 1'b0;
      free_w_q    <= 1'b0;
      free_wp1_q  <= 1'b0;
    end else if (!mem_wait) begin
      stage_e_q   <= stage_e_d;
      stage_m_q   <= stage_e_q;
      stage_w_q   <= stage_m_q;
      stage_wp1_q <= stage_w_q;
      rs1_e_q     <= rs1_e_d;
      rs2_e_q     <= rs2_e_d;
      rd1_e_q     <= rd1_e_d;
      rd2_e_q     <= rd2_e_d;
      ld_w_q      <= data_mem_bus_rd_data_m;
      ld_wp1_q    <= ld_w_q;
      // Qualifiers are registered so the forwarding unit sees no decode logic in its path.
      free_m_q    <= hzd_free(stage_e_q);
      free_w_q    <= free_m_q;
      free_wp1_q  <= free_w_q;
    end
  end

  // free_m_q already excludes rsd_m == ZERO, so a matching source is never ZERO.
  assign load2use = stage_e_q.v & stage_m_q.v & (stage_m_q.opcode == NEM_LW) & free_m_q &
                    ((rs1_e_q == stage_m_q.rsd) | (rs2_e_q == stage_m_q.rsd));

  mips_sat_counter #(
    .CNT_W(CNT_W)
  ) u_load2use_cnt (
    .clk(clk),
    .rst(rst),
    .en (~mem_wait),
    .inc(load2use),
    .cnt(load2use_cnt)
  );

  assign rs1_e                        = rs1_e_q;
  assign rs2_e                        = rs2_e_q;
  assign rsd_e                        = stage_e_q.rsd;
  assign intr_opcode_e                = stage_e_q.opcode;
  assign reg_write_e                  = stage_e_q.reg_write;
  assign reg_file_rd_data_1_e         = rd1_e_q;
  assign reg_file_rd_data_2_e         = rd2_e_q;
  assign rsd_m                        = stage_m_q.rsd;
  assign rsd_w                        = stage_w_q.rsd;
  assign rsd_w_plus1                  = stage_wp1_q.rsd;
  assign intr_opcode_m                = stage_m_q.opcode;
  assign intr_opcode_w                = stage_w_q.opcode;
  assign intr_opcode_w_plus1          = stage_wp1_q.opcode;
  assign reg_write_m                  = stage_m_q.reg_write & stage_m_q.v;
  assign reg_write_w                  = stage_w_q.reg_write & stage_w_q.v;
  assign reg_write_hzd_free_m         = free_m_q;
  assign reg_write_hzd_free_w         = free_w_q;
  assign reg_write_hzd_free_w_plus1   = free_wp1_q;
  assign data_mem_bus_rd_data_w       = ld_w_q;
  assign data_mem_bus_rd_data_w_plus1 = ld_wp1_q;

endmodule
